// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared width and FSM encodings for the iterative divider.
package div_unit_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: E-stage divide request/response bundle between pipeline and divider.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    modport master (output start, signed_div, annul, a, b, input busy, done, quot, rem);
    modport slave  (input start, signed_div, annul, a, b, output busy, done, quot, rem);
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider, quotient to LO and remainder to HI,
// one step per cycle with a stall request while working.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    logic [1:0]       state;
    logic [5:0]       count;
    logic [WIDTH-1:0] r, q, bm;
    logic             sa, sb, sd, bz;
    logic [WIDTH-1:0] a_abs, b_abs, r_nxt, q_nxt, q_fix, r_fix;
    logic [WIDTH:0]   rs, diff;
    logic             issue, last;

    always_comb begin
        a_abs = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        rs    = {r, q[WIDTH-1]};
        diff  = rs - {1'b0, bm};
        r_nxt = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
        q_nxt = {q[WIDTH-2:0], ~diff[WIDTH]};
        // With a zero divisor every step subtracts nothing, so r_nxt already ends as |a|.
        q_fix = bz ? '1 : (sd && (sa ^ sb)) ? -q_nxt : q_nxt;
        r_fix = (sd && sa) ? -r_nxt : r_nxt;
        issue = (state == DIV_IDLE) && bus.start && !bus.annul;
        last  = count == 6'(WIDTH - 1);
    end

    assign bus.busy = !rst && (issue || state == DIV_RUN);
    assign bus.done = state == DIV_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_IDLE;
            count    <= '0;
            r        <= '0;
            q        <= '0;
            bm       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            sd       <= 1'b0;
            bz       <= 1'b0;
            bus.quot <= '0;
            bus.rem  <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (issue) begin
                    state <= DIV_RUN;
                    count <= '0;
                    r     <= '0;
                    q     <= a_abs;
                    bm    <= b_abs;
                    sa    <= bus.signed_div && bus.a[WIDTH-1];
                    sb    <= bus.signed_div && bus.b[WIDTH-1];
                    sd    <= bus.signed_div;
                    bz    <= bus.b == '0;
                end
                DIV_RUN: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count + 6'd1;
                    // A flush always beats completion, even on the final step.
                    if (bus.annul) begin
                        state <= DIV_IDLE;
                    end else if (last) begin
                        state    <= DIV_DONE;
                        bus.quot <= q_fix;
                        bus.rem  <= r_fix;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus annul/reset corner sequences for div_unit.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    div_unit_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input string name);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = sd;
        bus.a = a;
        bus.b = b;
        #1 check({name, " busy c0"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        check({name, " busy c1"}, 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd33);
        check({name, " quot"}, bus.quot, eq);
        check({name, " rem"}, bus.rem, er);
        check({name, " busy at done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({name, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic no_done(input int cycles, input string name);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check({name, " no done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1};
        vecs[3] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5};
        vecs[4] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
        vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE};

        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.annul = 1'b0;
        bus.a = 32'd9;
        bus.b = 32'd3;
        #12;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quot", bus.quot, 32'd0);
        check("reset rem", bus.rem, 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, $sformatf("vec%0d", i));

        // start together with annul in IDLE is dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.a = 32'd50;
        bus.b = 32'd5;
        #1 check("annul issue busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        check("annul issue busy c1", 32'(bus.busy), 32'd0);
        no_done(40, "annul issue");

        // annul at RUN cycle 10, new DIVU at cycle 12
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        no_done(8, "annul pre");
        @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul idle busy", 32'(bus.busy), 32'd0);
        check("annul done", 32'(bus.done), 32'd0);
        check("annul quot kept", bus.quot, 32'd14);
        check("annul rem kept", bus.rem, 32'hFFFF_FFFE);
        run_div(1'b0, 32'd20, 32'd4, 32'd5, 32'd0, "after annul");

        // annul coinciding with the final RUN step
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd77;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        no_done(30, "annul last pre");
        @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul last done", 32'(bus.done), 32'd0);
        check("annul last busy", 32'(bus.busy), 32'd0);
        check("annul last quot", bus.quot, 32'd5);
        no_done(5, "annul last post");

        // asynchronous reset mid-RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        no_done(14, "rst pre");
        #2 rst = 1'b1;
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst quot", bus.quot, 32'd0);
        check("rst rem", bus.rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done(40, "rst post");
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
